// File: rtl/wb_bus_arbiter.sv
// Round-robin writeback arbiter: five EX unit results, each with its own FIFO,
// share one registered common-data-bus broadcast. Stall is asserted when a FIFO is full.
module wb_bus_arbiter #(
   parameter int                NUM_SRC     = 5,
   parameter int                COMMON_W    = 32,
   parameter int                TAG_W       = 5,
   parameter logic [TAG_W-1:0]  TAG_INVALID = '0,
   parameter int                DEPTH       = 2,
   parameter int                SRC_W       = $clog2(NUM_SRC)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [NUM_SRC*TAG_W-1:0]     src_target,
   input  logic [NUM_SRC*COMMON_W-1:0]  src_result,
   output logic [NUM_SRC-1:0]           src_stall,
   output logic [TAG_W-1:0]             cdb_target,
   output logic [COMMON_W-1:0]          cdb_result,
   output logic [SRC_W-1:0]             cdb_src
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_SRC - 1);

   logic [TAG_W-1:0]    mem_tag [NUM_SRC][DEPTH];
   logic [COMMON_W-1:0] mem_res [NUM_SRC][DEPTH];
   logic [PTR_W-1:0]    rd_ptr  [NUM_SRC];
   logic [PTR_W-1:0]    wr_ptr  [NUM_SRC];
   logic [CNT_W-1:0]    count   [NUM_SRC];
   logic [SRC_W-1:0]    rr;
   logic [NUM_SRC-1:0]  push;
   logic [NUM_SRC-1:0]  pop;
   logic                grant_vld;
   logic [SRC_W-1:0]    grant_idx;

   // Stall comes from the registered count only, so a same-cycle pop cannot release it.
   always_comb begin
      src_stall = '0;
      push      = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         src_stall[i] = (count[i] == CNT_FULL);
         push[i]      = (src_target[i*TAG_W +: TAG_W] != TAG_INVALID) && !src_stall[i] && !flush;
      end
   end

   always_comb begin : grant_scan
      int idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = 0;
      for (int k = 0; k < NUM_SRC; k++) begin
         idx = int'(rr) + k;
         if (idx >= NUM_SRC) idx = idx - NUM_SRC;
         if (!grant_vld && count[idx] != '0) begin
            grant_vld = 1'b1;
            grant_idx = SRC_W'(idx);
         end
      end
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < NUM_SRC; i++)
         pop[i] = grant_vld && !flush && (grant_idx == SRC_W'(i));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else if (flush) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) wr_ptr[i] <= (wr_ptr[i] == PTR_LAST) ? '0 : wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= (rd_ptr[i] == PTR_LAST) ? '0 : rd_ptr[i] + 1'b1;
            if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
            else if (pop[i] && !push[i]) count[i] <= count[i] - 1'b1;
         end
      end
   end

   // Payload storage needs no reset; validity is tracked by the counts.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (push[i]) begin
            mem_tag[i][wr_ptr[i]] <= src_target[i*TAG_W +: TAG_W];
            mem_res[i][wr_ptr[i]] <= src_result[i*COMMON_W +: COMMON_W];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_target <= TAG_INVALID;
         cdb_result <= '0;
         cdb_src    <= '0;
         rr         <= '0;
      end else if (flush) begin
         cdb_target <= TAG_INVALID;
         cdb_result <= '0;
         rr         <= '0;
      end else if (grant_vld) begin
         cdb_target <= mem_tag[grant_idx][rd_ptr[grant_idx]];
         cdb_result <= mem_res[grant_idx][rd_ptr[grant_idx]];
         cdb_src    <= grant_idx;
         rr         <= (grant_idx == SRC_LAST) ? '0 : grant_idx + 1'b1;
      end else begin
         cdb_target <= TAG_INVALID;
         cdb_result <= '0;
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: a queue-based model predicts each broadcast,
// a monitor compares the bus one step after every clock edge.
module tb_wb_bus_arbiter;

   localparam int NS    = 5;
   localparam int CW    = 32;
   localparam int TW    = 5;
   localparam int DEPTH = 2;
   localparam int SW    = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic [NS*TW-1:0]  src_target = '0;
   logic [NS*CW-1:0]  src_result = '0;
   logic [NS-1:0]     src_stall;
   logic [TW-1:0]     cdb_target;
   logic [CW-1:0]     cdb_result;
   logic [SW-1:0]     cdb_src;

   wb_bus_arbiter #(.NUM_SRC(NS), .COMMON_W(CW), .TAG_W(TW), .TAG_INVALID('0),
                    .DEPTH(DEPTH), .SRC_W(SW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .src_target(src_target), .src_result(src_result), .src_stall(src_stall),
      .cdb_target(cdb_target), .cdb_result(cdb_result), .cdb_src(cdb_src)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic [TW-1:0] tag; logic [CW-1:0] res; logic [SW-1:0] src;} cdb_t;
   typedef struct packed {logic [TW-1:0] tag; logic [CW-1:0] res;} ent_t;

   cdb_t          exp_q[$];
   ent_t          mq[NS][$];
   int            rr_m = 0;
   logic [SW-1:0] last_src = '0;
   logic [TW-1:0] drv_tag[NS];
   logic [CW-1:0] drv_res[NS];
   int            checks = 0;
   int            errors = 0;
   bit            mon_en = 1'b0;

   task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en && exp_q.size() > 0) begin
         cdb_t e;
         e = exp_q.pop_front();
         check({cdb_target, cdb_result, cdb_src} == e, "cdb",
               64'({cdb_target, cdb_result, cdb_src}), 64'(e));
      end
   end

   task automatic clear_model();
      for (int i = 0; i < NS; i++) begin
         mq[i].delete();
         drv_tag[i] = '0;
         drv_res[i] = '0;
      end
      exp_q.delete();
      rr_m     = 0;
      last_src = '0;
   endtask

   task automatic offer(input int i, input logic [TW-1:0] tag, input logic [CW-1:0] res);
      if (drv_tag[i] == '0) begin
         drv_tag[i] = tag;
         drv_res[i] = res;
      end
   endtask

   // One clock of stimulus; the model grants from the pre-edge contents, then appends accepted pushes.
   task automatic step(input bit fl);
      logic [NS-1:0] exp_stall;
      cdb_t          e;
      int            g;
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
         src_target[i*TW +: TW] = drv_tag[i];
         src_result[i*CW +: CW] = drv_res[i];
         exp_stall[i] = (mq[i].size() == DEPTH);
      end
      flush = fl;
      check(src_stall == exp_stall, "stall", 64'(src_stall), 64'(exp_stall));
      if (fl) begin
         for (int i = 0; i < NS; i++) begin
            mq[i].delete();
            drv_tag[i] = '0;
         end
         rr_m = 0;
         e = '{tag: '0, res: '0, src: last_src};
      end else begin
         g = -1;
         for (int k = 0; k < NS; k++)
            if (g < 0 && mq[(rr_m + k) % NS].size() > 0) g = (rr_m + k) % NS;
         if (g >= 0) begin
            ent_t h;
            h = mq[g].pop_front();
            last_src = SW'(g);
            rr_m = (g + 1) % NS;
            e = '{tag: h.tag, res: h.res, src: last_src};
         end else begin
            e = '{tag: '0, res: '0, src: last_src};
         end
         for (int i = 0; i < NS; i++) begin
            if (drv_tag[i] != '0 && !exp_stall[i]) begin
               mq[i].push_back('{tag: drv_tag[i], res: drv_res[i]});
               drv_tag[i] = '0;
            end
         end
      end
      exp_q.push_back(e);
   endtask

   initial begin
      int nxt;
      clear_model();
      repeat (3) @(negedge clk);
      check(cdb_target == '0, "rst_tag", 64'(cdb_target), 0);
      check(cdb_result == '0, "rst_res", 64'(cdb_result), 0);
      check(cdb_src == '0, "rst_src", 64'(cdb_src), 0);
      check(src_stall == '0, "rst_stall", 64'(src_stall), 0);
      rst = 1'b0;
      mon_en = 1'b1;

      // single-source latency
      offer(0, 5'd7, 32'hDEAD_BEEF);
      repeat (3) step(1'b0);

      // flush to rr=0, then all five sources at once
      step(1'b1);
      for (int i = 0; i < NS; i++) offer(i, TW'(i + 1), CW'(32'h100 + i));
      repeat (8) step(1'b0);

      // backpressure: mem 9,10,11 while alu stays busy
      nxt = 9;
      for (int c = 0; c < 14; c++) begin
         offer(0, TW'($urandom_range(1, 31)), $urandom);
         if (drv_tag[4] == '0 && nxt <= 11) begin
            offer(4, TW'(nxt), CW'(32'hA000 + nxt));
            nxt++;
         end
         step(1'b0);
      end
      repeat (4) step(1'b0);

      // fairness: alu every cycle, branch once
      for (int c = 0; c < 12; c++) begin
         offer(0, TW'($urandom_range(1, 31)), $urandom);
         if (c == 2) offer(3, 5'd20, 32'hB0B0_0003);
         step(1'b0);
      end
      repeat (4) step(1'b0);

      // flush with four buffered and jump presenting tag 12
      for (int i = 0; i < NS; i++) offer(i, TW'(i + 21), CW'(32'hF000 + i));
      step(1'b0);
      step(1'b0);
      offer(2, 5'd12, 32'h0000_0C0C);
      step(1'b1);
      repeat (4) step(1'b0);
      for (int i = 0; i < NS; i++) offer(i, TW'(i + 1), $urandom);
      repeat (7) step(1'b0);

      // randomized traffic with occasional flush
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NS; i++)
            if ($urandom_range(0, 99) < 40) offer(i, TW'($urandom_range(1, 31)), $urandom);
         step($urandom_range(0, 99) < 3);
      end

      // reset mid-stream with three results buffered
      offer(1, 5'd3, 32'h11); offer(3, 5'd4, 32'h22); offer(4, 5'd5, 32'h33);
      step(1'b0);
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      check(cdb_target == '0, "midrst_tag", 64'(cdb_target), 0);
      check(src_stall == '0, "midrst_stall", 64'(src_stall), 0);
      clear_model();
      src_target = '0;
      src_result = '0;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (10) step(1'b0);

      @(posedge clk);
      #2;
      check(exp_q.size() == 0, "drain", 64'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Schedules results from the five EX functional units onto one shared writeback/common-data-bus broadcast port, one result per cycle.
- Each unit output port (alu, forwarder, jump, branch, mem, in that source-index order) feeds a per-source FIFO.
- A round-robin scheduler drains the FIFOs into a registered broadcast.
- Per-source stall provides backpressure; flush discards in-flight results on misprediction.

Parameters:
- NUM_SRC, 5, number of requesting EX units; index 0=alu, 1=forwarder, 2=jump, 3=branch, 4=mem.
- COMMON_W, 32, result width.
- TAG_W, 5, instruction tag width.
- TAG_INVALID, 0, tag value meaning "no result".
- DEPTH, 2, per-source FIFO entries; must be a power of two and at least 1.
- SRC_W, $clog2(NUM_SRC), width of the source index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered results.
- src_target  in  NUM_SRC*TAG_W  per-source tag, flattened with source i at bits [i*TAG_W +: TAG_W]; TAG_INVALID means no request.
- src_result  in  NUM_SRC*COMMON_W  per-source result, flattened with source i at bits [i*COMMON_W +: COMMON_W].
- src_stall  out  NUM_SRC  per-source FIFO-full indication; the source must hold its target/result while its bit is set.
- cdb_target  out  TAG_W  broadcast tag; TAG_INVALID when idle.
- cdb_result  out  COMMON_W  broadcast value; 0 when idle.
- cdb_src  out  SRC_W  index of the source that produced the current broadcast.

Behaviour:
- Reset (async, rst=1):
  - All FIFOs empty; occupancy counts 0; read/write pointers 0.
  - Round-robin pointer rr=0.
  - cdb_target=TAG_INVALID, cdb_result=0, cdb_src=0.
  - src_stall=0 while rst is high.
  - Reset mid-operation drops all buffered results.
- Push:
  - At each rising edge, source i is written when src_target[i] != TAG_INVALID, src_stall[i]==0 and flush==0.
  - Entries are stored in arrival order.
- Stall:
  - src_stall[i] = (count_i == DEPTH), derived from the registered count only.
  - A same-cycle pop does not clear stall: no combinational path from grant to stall.
  - A source presenting a result while stalled is not sampled and must repeat it.
- Grant (combinational, every cycle):
  - Scan sources starting at rr, wrapping mod NUM_SRC.
  - The first non-empty FIFO wins; at most one grant per cycle.
- Broadcast (registered):
  - At the edge, the granted FIFO head is popped and loaded into cdb_target/cdb_result/cdb_src.
  - rr <= (g+1) mod NUM_SRC, where g is the granted index.
  - With no grant: cdb_target<=TAG_INVALID, cdb_result<=0, cdb_src and rr hold.
- Latency:
  - A result accepted at edge E appears on cdb at edge E+1 at the earliest; there is no bypass.
- Ordering:
  - Per source, strict FIFO order.
  - Across sources, round-robin with no starvation: any non-empty FIFO is granted within NUM_SRC cycles.
- Simultaneous push and pop on the same FIFO:
  - Both occur; count is unchanged.
  - Allowed only when not full, because a stalled source is not pushed.
- Pointer wrap:
  - FIFO read/write pointers wrap at DEPTH.
  - rr wraps from NUM_SRC-1 to 0.
- Flush (flush=1 at an edge):
  - All FIFOs emptied, rr<=0, cdb_target<=TAG_INVALID, cdb_result<=0.
  - Inputs presented in the flush cycle are discarded.
  - Flush has priority over push and grant.
- Counts use $clog2(DEPTH)+1 bits and must never exceed DEPTH.

Test Plan:
- Reset/idle: assert rst mid-stream with 3 results buffered -> immediately cdb_target=0, src_stall=0; after release and no requests, cdb_target stays 0 indefinitely.
- Single-source latency: alu presents tag 7, result 0xDEAD_BEEF for one cycle at edge E -> at edge E+1, cdb_target=7, cdb_result=0xDEADBEEF, cdb_src=0; at E+2, cdb_target=0.
- Round robin: all 5 sources present tags 1..5 in one cycle with rr=0 -> broadcasts tags 1,2,3,4,5 on five consecutive cycles, cdb_src 0..4; rr then wraps to 0.
- Backpressure: DEPTH=2; mem presents tags 9,10,11 back-to-back while the alu FIFO is kept non-empty -> src_stall[4]=1 once two entries are held; tag 11 is held until stall drops; mem broadcasts 9,10,11 in order with none lost or duplicated.
- Fairness under load: alu requests every cycle and branch requests once -> branch is broadcast within 2 cycles of being buffered; alu never starves.
- Flush: buffer 4 results, assert flush for one cycle while jump presents tag 12 -> next cycle cdb_target=0; no previously buffered tag or tag 12 is ever broadcast; rr=0.
